serial_add_unit: RTL and testbench

//  Bit-serial add/subtract engine built around one instance of the gate-level
//  1-bit full-adder cell, with a registered carry between bits.
//  It consumes one sum/cout pair per clock, LSB first, and assembles a WIDTH-bit

---
 rtl/serial_add_unit.sv | 121 ++++++++++++
 tb/tb_serial_add_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract unit: one full-adder cell, registered carry,
// LSB-first accumulation into a WIDTH-bit result with ALU flags.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (p & ci);
endmodule

module serial_add_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] nxt_acc;
  logic             carry;
  logic             c_msb_in;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic             msb_prev;

  fa_cell u_fa (
    .x  (op_a[0]),
    .y  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign nxt_acc  = {fa_s, acc[WIDTH-1:1]};
  assign last_bit = (count == CW'(WIDTH - 1));
  assign msb_prev = (count == CW'(WIDTH - 2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      c_msb_in  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          acc   <= nxt_acc;
          carry <= fa_co;
          count <= count + 1'b1;
          if (msb_prev) c_msb_in <= fa_co;
          // Final bit: publish result and flags in one step
          if (last_bit) begin
            result    <= nxt_acc;
            carry_out <= fa_co;
            overflow  <= c_msb_in ^ fa_co;
            negative  <= fa_s;
            zero      <= (nxt_acc == '0);
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_unit.sv
// Scoreboard bench for serial_add_unit at WIDTH=8 and WIDTH=64
// against an arithmetic reference model.
module tb_serial_add_unit;
  typedef struct packed {
    logic [63:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #2500 clk = ~clk;

  logic        start8 = 0, sub8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8, n8, z8, v8, c8;
  logic [7:0]  res8;
  logic        start64 = 0, sub64 = 0;
  logic [63:0] a64 = 0, b64 = 0;
  logic        busy64, done64, n64, z64, v64, c64;
  logic [63:0] res64;

  serial_add_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .sub(sub8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8),
    .negative(n8), .zero(z8), .overflow(v8), .carry_out(c8)
  );

  serial_add_unit #(.WIDTH(64)) u64 (
    .clk(clk), .reset_n(reset_n), .start(start64), .sub(sub64),
    .a(a64), .b(b64), .busy(busy64), .done(done64), .result(res64),
    .negative(n64), .zero(z64), .overflow(v64), .carry_out(c64)
  );

  int vectors = 0;
  int miscompares = 0;
  exp_t q8[$];
  exp_t q64[$];
  exp_t e8, e64;
  logic [63:0] last8 = 0, last64 = 0;
  int bc8 = 0, bc64 = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input int w, input logic [63:0] a,
                                 input logic [63:0] b, input logic s);
    exp_t e;
    logic [63:0] m, be;
    logic [64:0] f;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    be = (s ? ~b : b) & m;
    f = {1'b0, a & m} + {1'b0, be} + 65'(s);
    e.r = f[63:0] & m;
    e.c = f[w];
    e.n = e.r[w-1];
    e.z = (e.r == 64'd0);
    e.v = (a[w-1] == be[w-1]) && (e.r[w-1] != a[w-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      last8 = 0;
      bc8 = 0;
    end else begin
      chk("excl8", 64'(busy8 & done8), 64'd0);
      if (busy8) bc8++;
      if (done8) begin
        chk("done_expected8", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) begin
          e8 = q8.pop_front();
          chk("result8", 64'(res8), e8.r);
          chk("flags8", 64'({n8, z8, v8, c8}),
              64'({e8.n, e8.z, e8.v, e8.c}));
          chk("busy_len8", 64'(bc8), 64'd8);
          last8 = e8.r;
        end
        bc8 = 0;
      end else begin
        chk("hold8", 64'(res8), last8);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      last64 = 0;
      bc64 = 0;
    end else begin
      chk("excl64", 64'(busy64 & done64), 64'd0);
      if (busy64) bc64++;
      if (done64) begin
        chk("done_expected64", 64'(q64.size() > 0), 64'd1);
        if (q64.size() > 0) begin
          e64 = q64.pop_front();
          chk("result64", res64, e64.r);
          chk("flags64", 64'({n64, z64, v64, c64}),
              64'({e64.n, e64.z, e64.v, e64.c}));
          chk("busy_len64", 64'(bc64), 64'd64);
          last64 = e64.r;
        end
        bc64 = 0;
      end else begin
        chk("hold64", res64, last64);
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic s, input bit extra);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1;
    q8.push_back(model(8, 64'(a), 64'(b), s));
    @(negedge clk);
    start8 = 0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    n = 1;
    while (!done8 && n < 200) begin
      start8 = (extra && n == 3);
      @(negedge clk);
      n++;
    end
    chk("latency8", 64'(n), 64'd9);
    start8 = extra;
    @(negedge clk);
    start8 = 0;
    chk("done_pulse8", 64'(done8), 64'd0);
  endtask

  task automatic op64(input logic [63:0] a, input logic [63:0] b,
                      input logic s);
    int n;
    @(negedge clk);
    a64 = a; b64 = b; sub64 = s; start64 = 1;
    q64.push_back(model(64, a, b, s));
    @(negedge clk);
    start64 = 0;
    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    n = 1;
    while (!done64 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("latency64", 64'(n), 64'd65);
    @(negedge clk);
    chk("done_pulse64", 64'(done64), 64'd0);
  endtask

  initial begin
    #(5000 * 40000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #100;
    chk("rst_out8", 64'({busy8, done8, n8, z8, v8, c8, res8}), 64'd0);
    chk("rst_out64", 64'({busy64, done64, n64, z64, v64, c64}), 64'd0);
    chk("rst_res64", res64, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;

    op8(8'h05, 8'h03, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0);
    op8(8'h03, 8'h03, 1'b1, 1'b0);
    op8(8'h00, 8'h01, 1'b1, 1'b0);
    op8(8'h80, 8'h01, 1'b1, 1'b0);
    op8(8'h11, 8'h22, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 20; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    #100;
    reset_n = 0;
    #1;
    chk("midrst_out8", 64'({busy8, done8, n8, z8, v8, c8, res8}), 64'd0);
    q8.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);

    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    op64(64'd0, 64'd1, 1'b1);
    for (int i = 0; i < 5; i++)
      op64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));

    repeat (5) @(negedge clk);
    chk("queues_drained", 64'(q8.size() + q64.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
